// File: rtl/sprite_pkg.sv
// sprite_pkg
//   Types and constants for the sprite colour-index RAM. Both the loader and the
//   pixel draw path use them to form addresses.
//   Contents:
//     SPRITE_W / SPRITE_H / SPRITE_PIXELS  sprite geometry (20x20 = 400 pixels)
//     color_idx_t                          4-bit colour index
//     loader_state_e                       loader FSM states
//     slot_base()                          slot*400 built from shifts and adds
package sprite_pkg;

  localparam int SPRITE_W      = 20;
  localparam int SPRITE_H      = 20;
  localparam int SPRITE_PIXELS = SPRITE_W * SPRITE_H;

  typedef logic [3:0] color_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_LO,
    ST_HI,
    ST_DONE
  } loader_state_e;

  // 400 = 256 + 128 + 16, so no multiplier is needed.
  function automatic logic [15:0] slot_base(input logic [5:0] slot);
    logic [15:0] s;
    s = {10'b0, slot};
    return (s << 8) + (s << 7) + (s << 4);
  endfunction

endpackage

// File: rtl/sprite_ram_loader_if.sv
// sprite_ram_loader_if
//   Groups the byte-stream handshake and the RAM write port of the loader.
//   Signals:
//     in_data  [7:0]    {pixel n+1, pixel n} colour indices
//     in_valid          in_data valid
//     in_ready          byte accepted when in_valid & in_ready
//     wr_en             RAM write strobe
//     wr_addr [ADDR_W]  linear RAM address
//     wr_data [3:0]     colour index to write
//   Modports:
//     master  data source / RAM side (drives the stream, observes writes)
//     slave   the loader (consumes the stream, drives the write port)
interface sprite_ram_loader_if
  import sprite_pkg::*;
#(
  parameter int ADDR_W = 16
) ();

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  color_idx_t        wr_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen
//   Column/row/slot counters plus the linear RAM address they imply.
//   Ports:
//     Clk, Reset_n        clock, asynchronous active-low reset
//     load                set counters to (slot_first, row 0, col 0), address to slot_first*400
//     inc                 advance one pixel; address always steps by one
//     slot_first [5:0]    first slot of the load
//     slot_last  [5:0]    last slot of the load
//     addr [ADDR_W]       address of the current pixel
//     last                current pixel is the final pixel of slot_last
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              load,
  input  logic              inc,
  input  logic [5:0]        slot_first,
  input  logic [5:0]        slot_last,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [4:0] col;
  logic [4:0] row;
  logic [5:0] slot;
  logic [5:0] slot_end;

  logic col_wrap;
  logic row_wrap;

  always_comb begin
    col_wrap = (col == 5'(SPRITE_W - 1));
    row_wrap = (row == 5'(SPRITE_H - 1));
    last     = col_wrap && row_wrap && (slot == slot_end);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      col      <= '0;
      row      <= '0;
      slot     <= '0;
      slot_end <= '0;
      addr     <= '0;
    end else if (load) begin
      col      <= '0;
      row      <= '0;
      slot     <= slot_first;
      slot_end <= slot_last;
      addr     <= ADDR_W'(slot_base(slot_first));
    end else if (inc) begin
      // Slots are stored back to back, so the linear address needs no
      // correction at row or slot boundaries; the counters only track position.
      addr <= addr + 1'b1;
      if (col_wrap) begin
        col <= '0;
        if (row_wrap) begin
          row  <= '0;
          slot <= slot + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_ram_loader.sv
// sprite_ram_loader
//   Write side of the sprite colour-index RAM. Takes a byte stream (two colour
//   indices per byte, low nibble first) and writes consecutive 20x20 sprite slots
//   starting at sprite_first.
//   Parameters: NUM_SPRITES (slots in RAM), ADDR_W (RAM address width).
//   Ports:
//     Clk, Reset_n          clock, asynchronous active-low reset
//     start                 1-cycle load request, sampled only when idle
//     sprite_first [5:0]    first slot to write
//     sprite_count [5:0]    number of consecutive slots
//     bus (slave)           stream handshake + RAM write port
//     busy                  high from accepted start until the done cycle
//     done                  1-cycle pulse at end of load
//     error                 sticky range error, cleared by next accepted start
//     checksum [7:0]        only with LOADER_CHECKSUM_EN: mod-256 sum of bytes
//                           accepted since the last start
//   Optional feature macro: LOADER_CHECKSUM_EN
module sprite_ram_loader
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 38,
  parameter int ADDR_W      = 16
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                start,
  input  logic [5:0]          sprite_first,
  input  logic [5:0]          sprite_count,
  sprite_ram_loader_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                error
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]          checksum
`endif
);

  loader_state_e     state;
  logic [5:0]        first_q;
  logic [5:0]        count_q;
  color_idx_t        hi_q;

  logic [6:0]        slot_end;
  logic              range_bad;
  logic              take;
  logic              ag_load;
  logic              ag_inc;
  logic [5:0]        ag_slot_last;
  logic [ADDR_W-1:0] ag_addr;
  logic              ag_last;

  always_comb begin
    slot_end     = {1'b0, first_q} + {1'b0, count_q};
    range_bad    = slot_end > 7'(NUM_SPRITES);
    ag_slot_last = first_q + count_q - 1'b1;
    take         = (state == ST_LO) && bus.in_valid && bus.in_ready;
    ag_load      = (state == ST_CHECK) && (count_q != '0) && !range_bad;
    ag_inc       = take || (state == ST_HI);
  end

  sprite_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .load      (ag_load),
    .inc       (ag_inc),
    .slot_first(first_q),
    .slot_last (ag_slot_last),
    .addr      (ag_addr),
    .last      (ag_last)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= ST_IDLE;
      first_q      <= '0;
      count_q      <= '0;
      hi_q         <= '0;
      bus.in_ready <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      done      <= 1'b0;
      bus.wr_en <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            first_q <= sprite_first;
            count_q <= sprite_count;
            error   <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (count_q == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (range_bad) begin
            error <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            bus.in_ready <= 1'b1;
            state        <= ST_LO;
          end
        end
        ST_LO: begin
          // The low nibble goes straight out; only the high nibble is held
          // for the following cycle.
          if (take) begin
            hi_q         <= bus.in_data[7:4];
            bus.wr_en    <= 1'b1;
            bus.wr_addr  <= ag_addr;
            bus.wr_data  <= bus.in_data[3:0];
            bus.in_ready <= 1'b0;
            state        <= ST_HI;
          end
        end
        ST_HI: begin
          bus.wr_en   <= 1'b1;
          bus.wr_addr <= ag_addr;
          bus.wr_data <= hi_q;
          // Pixel totals are even, so the load can only end on a high nibble.
          if (ag_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            bus.in_ready <= 1'b1;
            state        <= ST_LO;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      checksum <= '0;
    end else if (state == ST_IDLE && start) begin
      checksum <= '0;
    end else if (take) begin
      checksum <= checksum + bus.in_data;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_ram_loader.sv
// tb_sprite_ram_loader
//   Directed sequence of loads with randomized stream data and in_valid gaps.
//   Expected writes come from a reference model: pixel p of a load lands at
//   first*400 + p with the nibble p%2 of stream byte p/2.
module tb_sprite_ram_loader;
  import sprite_pkg::*;

  localparam int NUM_SPRITES = 38;
  localparam int ADDR_W      = 16;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       start;
  logic [5:0] sprite_first;
  logic [5:0] sprite_count;
  logic       busy;
  logic       done;
  logic       error;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  sprite_ram_loader_if #(.ADDR_W(ADDR_W)) bus ();

  sprite_ram_loader #(
    .NUM_SPRITES(NUM_SPRITES),
    .ADDR_W     (ADDR_W)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .start       (start),
    .sprite_first(sprite_first),
    .sprite_count(sprite_count),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .error       (error)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor, sampled on the falling edge.
  logic [ADDR_W-1:0] wa_q[$];
  logic [3:0]        wd_q[$];
  int                done_cnt;

  always @(negedge Clk) begin
    if (bus.wr_en === 1'b1) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
    end
    if (done === 1'b1) done_cnt++;
  end

  // Results of the most recent run_load.
  logic [7:0] stim_q[$];
  int         acc;
  int         cyc_done;
  logic       busy1;
  logic       busy_done;
  logic       timed_out;
  logic       ready_after;

  task automatic run_load(input logic [5:0] first, input logic [5:0] count, input int nbytes,
                          input int gap_pct, input int fill, input int abort_after);
    int cyc;
    int budget;
    wa_q.delete();
    wd_q.delete();
    stim_q.delete();
    done_cnt    = 0;
    acc         = 0;
    cyc         = 0;
    timed_out   = 1'b1;
    ready_after = 1'b0;
    busy1       = 1'b0;
    busy_done   = 1'b1;
    budget      = 3000 * (int'(count) + 1);
    for (int i = 0; i < nbytes; i++)
      stim_q.push_back(fill < 0 ? 8'($urandom) : 8'(fill));
    @(negedge Clk);
    start        = 1'b1;
    sprite_first = first;
    sprite_count = count;
    while (cyc < budget) begin
      @(negedge Clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) busy1 = busy;
      if (done === 1'b1) begin
        timed_out = 1'b0;
        busy_done = busy;
        break;
      end
      if (abort_after > 0 && acc == abort_after) begin
        timed_out = 1'b0;
        break;
      end
      if (acc < nbytes && $urandom_range(99) >= gap_pct) begin
        bus.in_valid = 1'b1;
        bus.in_data  = stim_q[acc];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
      end
      if (bus.in_valid && bus.in_ready === 1'b1) acc++;
    end
    cyc_done     = cyc;
    bus.in_valid = 1'b0;
    if (abort_after == 0) begin
      // Offer more data after the end; none of it may be taken.
      repeat (3) begin
        @(negedge Clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        if (bus.in_ready !== 1'b0) ready_after = 1'b1;
      end
      bus.in_valid = 1'b0;
      @(negedge Clk);
    end
  endtask

  task automatic check_load(input logic [5:0] first, input logic [5:0] count);
    logic       bad_range;
    int         exp_writes;
    int         nbad;
    int         exp_addr;
    logic [3:0] exp_data;
    logic [7:0] b;
    logic [7:0] exp_sum;
    bad_range  = (int'(first) + int'(count)) > NUM_SPRITES;
    exp_writes = (count == 0 || bad_range) ? 0 : int'(count) * SPRITE_PIXELS;
    chk("done_timeout", timed_out, 1'b0);
    chk("write_count", wa_q.size(), exp_writes);
    chk("bytes_accepted", acc, exp_writes / 2);
    chk("done_pulses", done_cnt, 1);
    chk("error_flag", error, bad_range);
    chk("busy_after_start", busy1, 1'b1);
    chk("busy_at_done", busy_done, 1'b0);
    chk("in_ready_after_done", ready_after, 1'b0);
    nbad = 0;
    for (int p = 0; p < wa_q.size() && p < exp_writes; p++) begin
      exp_addr = int'(first) * SPRITE_PIXELS + p;
      b        = stim_q[p / 2];
      exp_data = (p % 2 == 1) ? b[7:4] : b[3:0];
      if (wa_q[p] !== ADDR_W'(exp_addr) || wd_q[p] !== exp_data) begin
        if (nbad == 0)
          $display("[TB] first bad write %0d: addr %0d data %0h, model addr %0d data %0h",
                   p, wa_q[p], wd_q[p], exp_addr, exp_data);
        nbad++;
      end
    end
    chk("write_seq_mismatches", nbad, 0);
    exp_sum = '0;
    for (int i = 0; i < exp_writes / 2; i++) exp_sum = exp_sum + stim_q[i];
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", checksum, exp_sum);
`else
    if (exp_sum == 8'hFF) $display("[TB] stream sum 0xFF");
`endif
  endtask

  initial begin
    logic [5:0] f;
    logic [5:0] c;
    int         maxc;

    Reset_n      = 1'b1;
    start        = 1'b0;
    sprite_first = '0;
    sprite_count = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset state
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_wr_en", bus.wr_en, 1'b0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_busy_done_error", {busy, done, error}, 3'b000);
`ifdef LOADER_CHECKSUM_EN
    chk("rst_checksum", checksum, 8'h00);
`endif
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    chk("idle_in_ready", bus.in_ready, 1'b0);
    chk("idle_busy", busy, 1'b0);

    // One slot of 0x21, always valid, extra bytes offered
    run_load(6'd0, 6'd1, 205, 0, 8'h21, 0);
    check_load(6'd0, 6'd1);
    chk("s0_first_data", wd_q.size() > 1 ? {wd_q[0], wd_q[1]} : 8'hxx, 8'h12);
    chk("s0_last_addr", wa_q.size() > 0 ? wa_q[wa_q.size()-1] : 16'hxxxx, 16'd399);

    // Background tile slot
    run_load(6'd37, 6'd1, 200, 10, -1, 0);
    check_load(6'd37, 6'd1);
    chk("s37_first_addr", wa_q.size() > 0 ? wa_q[0] : 16'hxxxx, 16'd14800);
    chk("s37_last_addr", wa_q.size() > 0 ? wa_q[wa_q.size()-1] : 16'hxxxx, 16'd15199);

    // Out of range: 36+3 > 38
    run_load(6'd36, 6'd3, 50, 0, -1, 0);
    check_load(6'd36, 6'd3);

    // Zero count: done two cycles after start, error cleared
    run_load(6'd4, 6'd0, 10, 0, -1, 0);
    check_load(6'd4, 6'd0);
    chk("count0_done_latency", cyc_done, 2);

    // Two slots with ~30% valid gaps; row and slot wraps
    run_load(6'd5, 6'd2, 400, 30, -1, 0);
    check_load(6'd5, 6'd2);
    chk("row_wrap_addr", wa_q.size() > 20 ? wa_q[20] : 16'hxxxx, 16'd2020);
    chk("slot_wrap_addr", wa_q.size() > 400 ? wa_q[400] : 16'hxxxx, 16'd2400);

    // Random legal loads
    repeat (2) begin
      f    = 6'($urandom_range(0, 36));
      maxc = NUM_SPRITES - int'(f);
      c    = 6'($urandom_range(1, maxc < 2 ? maxc : 2));
      run_load(f, c, int'(c) * 200, 20, -1, 0);
      check_load(f, c);
    end

    // Reset in the middle of a load, then restart at slot 1
    run_load(6'd0, 6'd1, 200, 0, -1, 50);
    chk("abort_bytes", acc, 50);
    Reset_n = 1'b0;
    #1;
    chk("abort_outputs", {bus.in_ready, bus.wr_en, busy, done, error}, 5'b0);
    chk("abort_wr_addr_data", {bus.wr_addr, bus.wr_data}, 20'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    run_load(6'd1, 6'd1, 200, 0, 8'h01, 0);
    check_load(6'd1, 6'd1);
    chk("restart_first_addr", wa_q.size() > 0 ? wa_q[0] : 16'hxxxx, 16'd400);
`ifdef LOADER_CHECKSUM_EN
    chk("restart_checksum_c8", checksum, 8'hC8);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
